// File: rtl/execution_unit_muldiv.sv
// Multi-cycle RV32M multiply/divide unit: iterative shift-add multiply and restoring
// divide, with single-cycle divide special cases and an optional combinational multiplier.
module execution_unit_muldiv #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0,
  parameter int RD_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [RD_W-1:0] rd_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] d_o,
  output logic [RD_W-1:0] rd_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   b_q, acc_u, acc_l;
  logic [XLEN-1:0]   nxt_u, nxt_l, final_res, fast_res;
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] fast_prod;
  logic              is_div, a_neg, b_neg, res_neg, div_zero, ovf, fast, accept;
  logic [XLEN-1:0]   a_mag, b_mag;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] sel_mul(input logic [2*XLEN-1:0] p, input logic neg,
                                              input logic [1:0] op);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (op == 2'b00) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  // Operand decode: MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed
  always_comb begin
    is_div   = op_i[2];
    a_neg    = (is_div ? !op_i[0] : (op_i[1] ^ op_i[0])) && rs1_i[XLEN-1];
    b_neg    = (is_div ? !op_i[0] : (op_i[1:0] == 2'b01)) && rs2_i[XLEN-1];
    a_mag    = cond_neg(rs1_i, a_neg);
    b_mag    = cond_neg(rs2_i, b_neg);
    res_neg  = (is_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = (rs2_i == '0);
    ovf      = !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    fast     = is_div ? (div_zero || ovf) : (FAST_MUL != 0);
    accept   = valid_i && ready_o && !flush_i;
  end

  assign fast_prod = (FAST_MUL != 0) ? ({{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag}) : '0;

  always_comb begin
    if (is_div)
      fast_res = div_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);
    else
      fast_res = sel_mul(fast_prod, res_neg, op_i[1:0]);
  end

  // One iteration: acc_u is the high product half / partial remainder, acc_l the
  // multiplier being consumed / dividend shifting out as quotient bits shift in
  always_comb begin
    sum     = {1'b0, acc_u} + (acc_l[0] ? {1'b0, b_q} : '0);
    shifted = {acc_u, acc_l[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    if (op_q[2]) begin
      nxt_u = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      nxt_l = {acc_l[XLEN-2:0], !diff[XLEN]};
    end else begin
      nxt_u = sum[XLEN:1];
      nxt_l = {sum[0], acc_l[XLEN-1:1]};
    end
    if (op_q[2])
      final_res = op_q[1] ? cond_neg(nxt_u, neg_q) : cond_neg(nxt_l, neg_q);
    else
      final_res = sel_mul({nxt_u, nxt_l}, neg_q, op_q[1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_comb begin
    ready_o = (state == IDLE) && !rst;
    valid_o = (state == DONE);
    busy_o  = (state != IDLE);
  end

  // Accept / CALC boundary: control, tag and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      d_o   <= '0;
      rd_o  <= '0;
    end else if (accept) begin
      cnt   <= CW'(XLEN-1);
      op_q  <= op_i;
      neg_q <= res_neg;
      rd_o  <= rd_i;
      if (fast) d_o <= fast_res;
    end else if (state == CALC && !flush_i) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) d_o <= final_res;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_u <= '0;
      acc_l <= a_mag;
      b_q   <= b_mag;
    end else if (state == CALC) begin
      acc_u <= nxt_u;
      acc_l <= nxt_l;
    end
  end

endmodule
